// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares one single-port 32-bit RAM between two requesters, using
//            fair arbitration with a bounded burst allowance.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int BURST_LEN = 4
) (
    input  logic              okClk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [31:0]       a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [31:0]       b_rdata,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int              RUN_W     = $clog2(BURST_LEN + 1);
    localparam logic [RUN_W-1:0] c_RUN_MAX = RUN_W'(BURST_LEN);
    localparam logic [RUN_W-1:0] c_RUN_ONE = RUN_W'(1);
    localparam logic            c_PORT_A  = 1'b0;
    localparam logic            c_PORT_B  = 1'b1;

    logic              owner_q, owner_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_re_q, ram_re_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              tag1_port_q, tag1_port_d;
    logic              tag2_vld_q, tag2_port_q;

    logic              w_gnt_a, w_gnt_b, w_any, w_sel, w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;

    // Under contention the owner keeps the RAM until its run is exhausted.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (a_req && b_req) begin
            if (run_q < c_RUN_MAX) begin
                w_gnt_a = (owner_q == c_PORT_A);
                w_gnt_b = (owner_q == c_PORT_B);
            end else begin
                w_gnt_a = (owner_q == c_PORT_B);
                w_gnt_b = (owner_q == c_PORT_A);
            end
        end else begin
            w_gnt_a = a_req;
            w_gnt_b = b_req;
        end
    end

    assign w_any   = w_gnt_a | w_gnt_b;
    assign w_sel   = w_gnt_b;
    assign w_we    = w_sel ? b_we    : a_we;
    assign w_addr  = w_sel ? b_addr  : a_addr;
    assign w_wdata = w_sel ? b_wdata : a_wdata;

    always_comb begin
        owner_d = owner_q;
        run_d   = run_q;
        if (w_any) begin
            if (w_sel == owner_q) begin
                if (run_q < c_RUN_MAX) begin
                    run_d = run_q + c_RUN_ONE;
                end
            end else begin
                owner_d = w_sel;
                run_d   = c_RUN_ONE;
            end
        end
    end

    always_comb begin
        ram_we_d    = w_any & w_we;
        ram_re_d    = w_any & ~w_we;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        tag1_port_d = tag1_port_q;
        if (w_any) begin
            ram_addr_d  = w_addr;
            ram_wdata_d = w_wdata;
            tag1_port_d = w_sel;
        end
    end

    always_ff @(posedge okClk) begin
        if (reset) begin
            owner_q     <= c_PORT_B;
            run_q       <= c_RUN_MAX;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            tag1_port_q <= 1'b0;
            tag2_vld_q  <= 1'b0;
            tag2_port_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            run_q       <= run_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            tag1_port_q <= tag1_port_d;
            tag2_vld_q  <= ram_re_q;
            tag2_port_q <= tag1_port_q;
        end
    end

    // ram_rdata is the RAM's own registered output, present the cycle after ram_re.
    assign a_gnt     = w_gnt_a;
    assign b_gnt     = w_gnt_b;
    assign a_rvalid  = tag2_vld_q & (tag2_port_q == c_PORT_A);
    assign b_rvalid  = tag2_vld_q & (tag2_port_q == c_PORT_B);
    assign a_rdata   = a_rvalid ? ram_rdata : 32'h0;
    assign b_rdata   = b_rvalid ? ram_rdata : 32'h0;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port 32-bit RAM (1-cycle registered read, same timing as the pseudoRAM block) between two requesters on okClk.
- Port A is normally the okRegisterBridge side; port B is a pipe streaming engine.
- Fair arbitration with a bounded burst allowance, so a streaming pipe cannot starve register access and vice versa.
- Read data is routed back to the issuing port with a valid strobe.

Parameters:
ADDR_W, 10, RAM address width (1024 words)
BURST_LEN, 4, max consecutive grants to one port while the other port is requesting (>=1)

Ports:
okClk  input  1  clock
reset  input  1  reset, synchronous, active-high
a_req  input  1  port A access request; hold req/we/addr/wdata stable until a_gnt
a_we  input  1  1 = write, 0 = read
a_addr  input  ADDR_W  word address
a_wdata  input  32  write data
a_gnt  output  1  combinational grant; access accepted this cycle
a_rvalid  output  1  one-cycle strobe, read data for port A
a_rdata  output  32  read data (valid only with a_rvalid)
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  (same as port A, for port B)
ram_we  output  1  registered RAM write strobe
ram_re  output  1  registered RAM read strobe
ram_addr  output  ADDR_W  registered RAM address
ram_wdata  output  32  registered RAM write data
ram_rdata  input  32  RAM read data, valid the cycle after ram_re

Behaviour:
- State: owner (A/B), run counter (consecutive grants to owner, saturates at BURST_LEN), rd_tag pipeline.
- Reset values: owner=B, run=BURST_LEN (exhausted), ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, rd tags cleared, a_rvalid=b_rvalid=0, a_rdata/b_rdata=0.
- Arbitration (combinational each cycle):
  - Only one port requests: grant it.
  - Both request and run<BURST_LEN: grant owner.
  - Both request and run>=BURST_LEN: grant the other port.
  - Neither requests: no grant; owner and run unchanged.
- Grant update at the clock edge:
  - Grant to owner: run=min(run+1, BURST_LEN).
  - Grant to non-owner: owner=granted port, run=1.
- At most one gnt per cycle; gnt is never asserted without the matching req.
- Command issue: in grant cycle T the granted port's we/addr/wdata are registered, so ram_we or ram_re=1 in T+1 (mutually exclusive). No grant: ram_we=ram_re=0, ram_addr/ram_wdata hold.
- Read return:
  - Port tag is registered alongside ram_re (T+1) and delayed one more cycle.
  - In T+2: x_rvalid=1 for one cycle, with x_rdata=ram_rdata registered from T+1.
  - Other port's rvalid stays 0.
- Read latency is grant-to-rvalid = 2 cycles. Throughput is 1 access/cycle total, and back-to-back reads from alternating ports return in issue order.
- Ordering: accesses reach the RAM in grant order, so a read granted after a write to the same address returns the new data.
- Reset mid-operation: in-flight reads are dropped (no rvalid) and ram_we/ram_re are 0 from the cycle after reset. A gnt asserted during a reset cycle is not issued; the requester must re-request.
- Addresses wider than the RAM are the integrator's concern; the arbiter passes ADDR_W bits unmodified.

Test Plan:
- A write addr 0x005 data 0xDEADBEEF -> a_gnt same cycle; next cycle ram_we=1, ram_addr=0x005, ram_wdata=0xDEADBEEF. Then A read 0x005 -> a_rvalid 2 cycles after a_gnt with a_rdata=0xDEADBEEF; b_rvalid stays 0.
- Both ports request continuously from reset, BURST_LEN=4 -> grant sequence A,A,A,A,B,B,B,B,A,... with exactly one gnt per cycle.
- B alone for 10 cycles -> b_gnt every cycle, run saturates at 4. A then requests -> a_gnt in the first contention cycle.
- Alternating reads A@0x010 (data 0x11111111), B@0x020 (data 0x22222222), back-to-back -> a_rvalid then b_rvalid on consecutive cycles with correct data, never swapped.
- B writes 0x0AA=0x12345678 and A reads 0x0AA in the next cycle -> a_rdata=0x12345678.
- A read granted, reset asserted the next cycle -> no a_rvalid; all ram_* strobes 0; after reset, contention grants A first.
